// File: rtl/down_counter_sync_pkg.sv
// Shared types and defaults for the down counter family.
// State encoding and default geometry live here.
package down_counter_sync_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam int DEF_WIDTH   = 3;
  localparam int DEF_MODULUS = 8;

endpackage

// File: rtl/down_counter_sync.sv
// Loadable modulo-MODULUS down counter with wrap and one-shot modes.
// Flags zero (comb), underflow pulse and one-shot completion (registered).
module down_counter_sync
  import down_counter_sync_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             OneShot,
  output logic [WIDTH-1:0] S,
  output logic             Zero,
  output logic             Borrow,
  output logic             Done
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  state_t           st, st_nxt;
  logic [WIDTH-1:0] s_nxt;
  logic             borrow_nxt;
  logic             done_nxt;

  always_comb begin
    s_nxt      = S;
    borrow_nxt = 1'b0;
    done_nxt   = Done;
    st_nxt     = st;
    if (Load) begin
      s_nxt    = (LoadValue > TOP) ? TOP : LoadValue;
      done_nxt = 1'b0;
      st_nxt   = ST_RUN;
    end else if (st == ST_HALT) begin
      s_nxt    = '0;
      done_nxt = 1'b1;
    end else if (Enable) begin
      if (S != '0) begin
        s_nxt = S - 1'b1;
      end else begin
        borrow_nxt = 1'b1;
        // OneShot only matters on the zero step
        if (OneShot) begin
          s_nxt    = '0;
          done_nxt = 1'b1;
          st_nxt   = ST_HALT;
        end else begin
          s_nxt = TOP;
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      S      <= TOP;
      Borrow <= 1'b0;
      Done   <= 1'b0;
      st     <= ST_RUN;
    end else begin
      S      <= s_nxt;
      Borrow <= borrow_nxt;
      Done   <= done_nxt;
      st     <= st_nxt;
    end
  end

  assign Zero = (S == '0);

endmodule

// File: tb/tb_down_counter_sync.sv
// Directed bench for down_counter_sync: mod-8 instance plus
// a mod-6 instance for the clamp-on-load boundary.
module tb_down_counter_sync;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Enable = 1'b0;
  logic       Load = 1'b0;
  logic [2:0] LoadValue = '0;
  logic       OneShot = 1'b0;

  logic [2:0] S8, S6;
  logic       Zero8, Zero6;
  logic       Borrow8, Borrow6;
  logic       Done8, Done6;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  down_counter_sync #(.WIDTH(3), .MODULUS(8)) u_m8 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Load(Load),
    .LoadValue(LoadValue), .OneShot(OneShot),
    .S(S8), .Zero(Zero8), .Borrow(Borrow8), .Done(Done8)
  );

  down_counter_sync #(.WIDTH(3), .MODULUS(6)) u_m6 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Load(Load),
    .LoadValue(LoadValue), .OneShot(OneShot),
    .S(S6), .Zero(Zero6), .Borrow(Borrow6), .Done(Done6)
  );

  logic [2:0] wrap_s [9] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2,
                             3'd1, 3'd0, 3'd7, 3'd6};
  logic       wrap_b [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic       wrap_z [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
  logic [2:0] os_s [6] = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
  logic       os_b [6] = '{0, 0, 0, 1, 0, 0};
  logic       os_d [6] = '{0, 0, 0, 1, 1, 1};

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #12;
    checks++;
    if (S8 !== 3'd7 || Zero8 !== 1'b0 || Borrow8 !== 1'b0 || Done8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_m8: S=%0d Z=%b B=%b D=%b want S=7 Z=0 B=0 D=0",
               S8, Zero8, Borrow8, Done8);
    end
    checks++;
    if (S6 !== 3'd5 || Done6 !== 1'b0) begin
      failures++;
      $display("FAIL reset_m6: S=%0d D=%b want S=5 D=0", S6, Done6);
    end
    @(negedge Clock);
    Reset = 1'b0;
    Enable = 1'b1;
    tick();
    tick();
    tick();
    Enable = 1'b0;
    checks++;
    if (S8 !== 3'd4) begin
      failures++;
      $display("FAIL pre_midreset: S=%0d want 4", S8);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (S8 !== 3'd7) begin
      failures++;
      $display("FAIL midcount_reset: S=%0d want 7", S8);
    end
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_wrap();
    OneShot = 1'b0;
    Enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (S8 !== wrap_s[i] || Borrow8 !== wrap_b[i] ||
          Zero8 !== wrap_z[i] || Done8 !== 1'b0) begin
        failures++;
        $display("FAIL wrap[%0d]: S=%0d B=%b Z=%b D=%b want S=%0d B=%b Z=%b D=0",
                 i, S8, Borrow8, Zero8, Done8, wrap_s[i], wrap_b[i], wrap_z[i]);
      end
    end
    Enable = 1'b0;
  endtask

  task automatic test_oneshot();
    Load = 1'b1;
    LoadValue = 3'd3;
    tick();
    Load = 1'b0;
    checks++;
    if (S8 !== 3'd3 || Borrow8 !== 1'b0) begin
      failures++;
      $display("FAIL os_load: S=%0d B=%b want S=3 B=0", S8, Borrow8);
    end
    OneShot = 1'b1;
    Enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (S8 !== os_s[i] || Borrow8 !== os_b[i] || Done8 !== os_d[i]) begin
        failures++;
        $display("FAIL oneshot[%0d]: S=%0d B=%b D=%b want S=%0d B=%b D=%b",
                 i, S8, Borrow8, Done8, os_s[i], os_b[i], os_d[i]);
      end
    end
    Enable = 1'b0;
    OneShot = 1'b0;
  endtask

  task automatic test_halt_load();
    Load = 1'b1;
    LoadValue = 3'd5;
    tick();
    Load = 1'b0;
    checks++;
    if (S8 !== 3'd5 || Done8 !== 1'b0) begin
      failures++;
      $display("FAIL halt_load: S=%0d D=%b want S=5 D=0", S8, Done8);
    end
    Enable = 1'b1;
    tick();
    Enable = 1'b0;
    checks++;
    if (S8 !== 3'd4 || Done8 !== 1'b0) begin
      failures++;
      $display("FAIL halt_resume: S=%0d D=%b want S=4 D=0", S8, Done8);
    end
  endtask

  task automatic test_hold();
    Enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (S8 !== 3'd4 || Borrow8 !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: S=%0d B=%b want S=4 B=0", i, S8, Borrow8);
      end
    end
  endtask

  task automatic test_clamp();
    Load = 1'b1;
    LoadValue = 3'd7;
    tick();
    Load = 1'b0;
    checks++;
    if (S6 !== 3'd5) begin
      failures++;
      $display("FAIL clamp_m6: S=%0d want 5", S6);
    end
    checks++;
    if (S8 !== 3'd7) begin
      failures++;
      $display("FAIL noclamp_m8: S=%0d want 7", S8);
    end
    Load = 1'b1;
    Enable = 1'b1;
    LoadValue = 3'd2;
    tick();
    Load = 1'b0;
    Enable = 1'b0;
    checks++;
    if (S6 !== 3'd2 || Borrow6 !== 1'b0) begin
      failures++;
      $display("FAIL load_wins: S=%0d B=%b want S=2 B=0", S6, Borrow6);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_oneshot();
    test_halt_load();
    test_hold();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
